int_sequencer: RTL and testbench

- Interrupt sequencer sitting directly upstream of the control unit; it generates the INT input the control unit decodes.
- Detects a rising edge on the external interrupt line and waits for an instruction boundary.
- Holds fetch while in-flight instructions drain, then drives INT for two cycles: push PC, then push flags.
- Finally redirects fetch to the interrupt vector. One further request arriving while busy is queued.

---
 rtl/int_seq_if.sv | 27 ++
 rtl/int_sequencer.sv | 149 ++++++++++++++
 tb/tb_int_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_seq_if.sv
// Handshake bundle between the interrupt sequencer and the surrounding pipeline:
// request/qualifier inputs plus the INT/fetch-control outputs.
interface int_seq_if #(
    parameter int PC_W = 32
);
    logic            IntReq;
    logic            IntEn;
    logic            Boundary;
    logic            Stall;
    logic            INT;
    logic            IntStage;
    logic            FetchHold;
    logic            LoadVector;
    logic [PC_W-1:0] VectorPC;
    logic            IntAck;
    logic            Busy;

    modport master (
        output IntReq, IntEn, Boundary, Stall,
        input  INT, IntStage, FetchHold, LoadVector, VectorPC, IntAck, Busy
    );

    modport slave (
        input  IntReq, IntEn, Boundary, Stall,
        output INT, IntStage, FetchHold, LoadVector, VectorPC, IntAck, Busy
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt sequencer: edge-detects IntReq, waits for a boundary, drains the
// pipeline, drives the two INT push cycles and strobes the vector load.
module int_sequencer #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] VECTOR_ADDR  = {PC_W{1'b0}},
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic     clk,
    input  logic     rst,
    int_seq_if.slave bus
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PEND     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_PUSH_PC  = 3'd3,
        ST_PUSH_FLG = 3'd4,
        ST_VECTOR   = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic            queued_r, queued_s;
    logic            req_q_r;
    logic            edge_s;

    logic            int_r, int_s;
    logic            stage_r, stage_s;
    logic            hold_r, hold_s;
    logic            lv_r, lv_s;
    logic            busy_r, busy_s;
    logic [PC_W-1:0] vpc_r, vpc_s;

    assign edge_s = bus.IntReq & ~req_q_r;

    // Next-state, drain counter, one-deep request queue and output decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        queued_s = queued_r;

        // In IDLE the pending request is consumed; a coincident edge re-queues.
        if (state_r == ST_IDLE) begin
            queued_s = queued_r & edge_s;
        end else begin
            queued_s = queued_r | edge_s;
        end

        case (state_r)
            ST_IDLE: begin
                if (edge_s || queued_r) begin
                    state_s = ST_PEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (bus.IntEn && bus.Boundary && !bus.Stall) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_s = ST_PUSH_PC;
                    end else begin
                        state_s = ST_DRAIN;
                        cnt_s   = CNT_INIT;
                    end
                end else begin
                    state_s = ST_PEND;
                end
            end
            ST_DRAIN: begin
                if (!bus.Stall) begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = ST_PUSH_PC;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_PUSH_PC: begin
                if (!bus.Stall) begin
                    state_s = ST_PUSH_FLG;
                end else begin
                    state_s = ST_PUSH_PC;
                end
            end
            ST_PUSH_FLG: begin
                if (!bus.Stall) begin
                    state_s = ST_VECTOR;
                end else begin
                    state_s = ST_PUSH_FLG;
                end
            end
            ST_VECTOR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies track the state register.
        int_s   = (state_s == ST_PUSH_PC) || (state_s == ST_PUSH_FLG);
        stage_s = (state_s == ST_PUSH_FLG);
        hold_s  = (state_s == ST_DRAIN) || (state_s == ST_PUSH_PC) || (state_s == ST_PUSH_FLG);
        lv_s    = (state_s == ST_VECTOR);
        busy_s  = (state_s != ST_IDLE);
        vpc_s   = (state_s == ST_VECTOR) ? VECTOR_ADDR : {PC_W{1'b0}};
    end

    // State, counter, queue, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            queued_r <= 1'b0;
            req_q_r  <= 1'b0;
            int_r    <= 1'b0;
            stage_r  <= 1'b0;
            hold_r   <= 1'b0;
            lv_r     <= 1'b0;
            busy_r   <= 1'b0;
            vpc_r    <= {PC_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            queued_r <= queued_s;
            req_q_r  <= bus.IntReq;
            int_r    <= int_s;
            stage_r  <= stage_s;
            hold_r   <= hold_s;
            lv_r     <= lv_s;
            busy_r   <= busy_s;
            vpc_r    <= vpc_s;
        end
    end

    assign bus.INT        = int_r;
    assign bus.IntStage   = stage_r;
    assign bus.FetchHold  = hold_r;
    assign bus.LoadVector = lv_r;
    assign bus.IntAck     = lv_r;
    assign bus.VectorPC   = vpc_r;
    assign bus.Busy       = busy_r;
endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: a DRAIN_CYCLES=3 and a DRAIN_CYCLES=0 instance share
// stimulus and are checked against a progress-counter reference model.
module tb_int_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0;
    logic en  = 1'b0;
    logic bnd = 1'b0;
    logic stl = 1'b0;

    int checks = 0;
    int errors = 0;

    int_seq_if #(.PC_W(32)) b0 ();
    int_seq_if #(.PC_W(32)) b1 ();

    assign b0.IntReq = req;  assign b1.IntReq = req;
    assign b0.IntEn = en;    assign b1.IntEn = en;
    assign b0.Boundary = bnd; assign b1.Boundary = bnd;
    assign b0.Stall = stl;   assign b1.Stall = stl;

    int_sequencer #(.PC_W(32), .VECTOR_ADDR(32'h0000_0000), .DRAIN_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    int_sequencer #(.PC_W(32), .VECTOR_ADDR(32'h0000_1F00), .DRAIN_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    // Reference model: a sequence is "active" with a progress position
    // 0 = waiting for enable/boundary, 1..D = drain, D+1/D+2 = pushes, D+3 = vector.
    bit          m_busy [2];
    int          m_pos  [2];
    bit          m_q    [2];
    bit          m_prev;
    int          dcy    [2] = '{3, 0};
    logic [31:0] vaddr  [2] = '{32'h0000_0000, 32'h0000_1F00};

    function automatic logic [37:0] exp_vec(int i);
        bit a = m_busy[i];
        int p = m_pos[i];
        int d = dcy[i];
        bit iv = a && (p == d + 1 || p == d + 2);
        bit st = a && (p == d + 2);
        bit hd = a && (p >= 1) && (p <= d + 2);
        bit lv = a && (p == d + 3);
        return {iv, st, hd, lv, lv, a, lv ? vaddr[i] : 32'h0};
    endfunction

    function automatic logic [37:0] got_vec(int i);
        if (i == 0)
            return {b0.INT, b0.IntStage, b0.FetchHold, b0.LoadVector, b0.IntAck, b0.Busy, b0.VectorPC};
        else
            return {b1.INT, b1.IntStage, b1.FetchHold, b1.LoadVector, b1.IntAck, b1.Busy, b1.VectorPC};
    endfunction

    task automatic step();
        bit e;
        @(posedge clk);
        e = req & ~m_prev;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_busy[i] = 0; m_pos[i] = 0; m_q[i] = 0;
            end else if (!m_busy[i]) begin
                if (e || m_q[i]) begin m_busy[i] = 1; m_pos[i] = 0; end
                m_q[i] = m_q[i] & e;
            end else begin
                m_q[i] = m_q[i] | e;
                if (m_pos[i] == 0) begin
                    if (en && bnd && !stl) m_pos[i] = 1;
                end else if (m_pos[i] == dcy[i] + 3) begin
                    m_busy[i] = 0; m_pos[i] = 0;
                end else if (!stl) begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
        m_prev = rst ? req : 1'b0;
        #1;
    endtask

    task automatic idle(int n);
        req = 0; en = 1; bnd = 1; stl = 0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 0; req = 1; en = 1; bnd = 1; stl = 0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 38'd0) begin
                errors++; $display("FAIL reset_outputs dut%0d got %h exp 0", i, got_vec(i));
            end
        end
        // IntReq held high across release is an edge on the first live cycle.
        rst = 1;
        step();
        checks++;
        if (b0.Busy !== 1'b1) begin
            errors++; $display("FAIL reset_release_edge got Busy=%b exp 1", b0.Busy);
        end
        idle(20);
    endtask

    task automatic test_latency();
        int ti[2] = '{-1, -1};
        int tl[2] = '{-1, -1};
        idle(4);
        req = 1;
        for (int c = 1; c <= 12; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL latency dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (b0.INT && ti[0] < 0) ti[0] = c;
            if (b1.INT && ti[1] < 0) ti[1] = c;
            if (b0.LoadVector && tl[0] < 0) tl[0] = c;
            if (b1.LoadVector && tl[1] < 0) tl[1] = c;
            if (c == 6) begin
                checks++;
                if (b0.IntStage !== 1'b1) begin
                    errors++; $display("FAIL latency_stage got %b exp 1", b0.IntStage);
                end
            end
            if (c == 8) begin
                checks++;
                if (b0.Busy !== 1'b0) begin
                    errors++; $display("FAIL latency_idle got %b exp 0", b0.Busy);
                end
            end
            if (c == 3) req = 0;
        end
        checks++;
        if (ti[0] != 5 || tl[0] != 7) begin
            errors++; $display("FAIL latency_d3 got int@%0d lv@%0d exp int@5 lv@7", ti[0], tl[0]);
        end
        checks++;
        if (ti[1] != 2 || tl[1] != 4) begin
            errors++; $display("FAIL latency_d0 got int@%0d lv@%0d exp int@2 lv@4", ti[1], tl[1]);
        end
    endtask

    task automatic test_stall();
        int ti0 = -1;
        int tl[2] = '{-1, -1};
        int nint = 0;
        idle(4);
        req = 1;
        for (int c = 1; c <= 14; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL stall dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (b0.INT) nint++;
            if (b0.INT && ti0 < 0) ti0 = c;
            if (b0.LoadVector && tl[0] < 0) tl[0] = c;
            if (b1.LoadVector && tl[1] < 0) tl[1] = c;
            stl = (c == 3 || c == 6);
            if (c == 3) req = 0;
        end
        stl = 0;
        // Stall in cycle 3 lengthens drain; stall in cycle 6 holds PUSH_PC one extra cycle.
        checks++;
        if (ti0 != 6 || tl[0] != 9 || nint != 3) begin
            errors++; $display("FAIL stall_d3 got int@%0d lv@%0d nint=%0d exp 6 9 3", ti0, tl[0], nint);
        end
        checks++;
        if (tl[1] != 5) begin
            errors++; $display("FAIL stall_d0 got lv@%0d exp lv@5", tl[1]);
        end
    endtask

    task automatic test_inten();
        int ti[2] = '{-1, -1};
        idle(4);
        req = 1; en = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL inten dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (c <= 10) begin
                checks++;
                if ({b0.Busy, b0.FetchHold, b0.INT} !== 3'b100) begin
                    errors++; $display("FAIL inten_pend cyc %0d got %b exp 100", c, {b0.Busy, b0.FetchHold, b0.INT});
                end
            end
            if (b0.INT && ti[0] < 0) ti[0] = c;
            if (b1.INT && ti[1] < 0) ti[1] = c;
            if (c == 2) req = 0;
            en = (c >= 10);
        end
        checks++;
        if (ti[0] != 14 || ti[1] != 11) begin
            errors++; $display("FAIL inten_start got %0d/%0d exp 14/11", ti[0], ti[1]);
        end
    endtask

    task automatic test_queue();
        int nlv = 0;
        idle(4);
        req = 1;
        // Edges at 0, 5 (PUSH_PC, queued), 7 (VECTOR, dropped) and 15 (second VECTOR, queued).
        for (int c = 1; c <= 30; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL queue dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (b0.LoadVector) nlv++;
            req = (c == 5 || c == 7 || c == 15);
        end
        checks++;
        if (nlv != 3) begin
            errors++; $display("FAIL queue_pulses got %0d exp 3", nlv);
        end
    endtask

    task automatic test_reset_mid();
        int nlv = 0;
        int tl = -1;
        idle(4);
        req = 1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 3) req = 0;
        end
        checks++;
        if (b0.IntStage !== 1'b1) begin
            errors++; $display("FAIL midrst_setup got stage %b exp 1", b0.IntStage);
        end
        rst = 0;
        step();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 38'd0) begin
                errors++; $display("FAIL midrst_outputs dut%0d got %h exp 0", i, got_vec(i));
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (b0.LoadVector) nlv++;
        end
        req = 1;
        for (int c = 1; c <= 12; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL midrst_rerun dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (b0.LoadVector) nlv++;
            if (b0.LoadVector && tl < 0) tl = c;
            if (c == 3) req = 0;
        end
        checks++;
        if (nlv != 1 || tl != 7) begin
            errors++; $display("FAIL midrst_pulses got n=%0d lv@%0d exp n=1 lv@7", nlv, tl);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            req = ($urandom_range(0, 3) == 0) ? ~req : req;
            en  = ($urandom_range(0, 3) != 0);
            bnd = ($urandom_range(0, 1) == 1);
            stl = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL random dut%0d cyc %0d got %h exp %h", i, c, got_vec(i), exp_vec(i));
                end
            end
        end
        rst = 1;
        idle(30);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_inten();
        test_queue();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
